tmds_dec: RTL and testbench

TMDS_DEC -- requirements
Module: tmds_dec

---
 rtl/tmds_pkg.sv | 14 +
 rtl/tmds_align_fsm.sv | 105 ++++++++++
 rtl/tmds_dec.sv | 129 ++++++++++++
 tb/tb_tmds_dec.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and state types, used by both encoder and decoder.
package tmds_pkg;

  localparam logic [9:0] CTL_00  = 10'b1101010100;
  localparam logic [9:0] CTL_01  = 10'b0010101011;
  localparam logic [9:0] CTL_10  = 10'b0101010100;
  localparam logic [9:0] CTL_11  = 10'b1010101011;
  localparam logic [9:0] GB_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_CH1  = 10'b0100110011;

  typedef enum logic [1:0] {ST_HUNT, ST_SETTLE, ST_LOCKED} align_st_e;
  typedef enum logic [1:0] {SYM_VID, SYM_CTL, SYM_GB}      sym_cls_e;

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment tracker: hunts for a control-token run, requests bitslips on
// timeout, and drops lock when the video error rate gets too high.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 16,
  parameter int SLIP_TIMEOUT = 4096,
  parameter int SETTLE_CYC   = 16,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_THRESH   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sym_val_i,
  input  logic sym_ctl_i,
  input  logic sym_err_i,
  output logic bitslip_o,
  output logic locked_o
);

  localparam int TMAX = (SLIP_TIMEOUT > ERR_WINDOW) ? SLIP_TIMEOUT : ERR_WINDOW;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(LOCK_CNT + 1);
  localparam int SW   = $clog2(SETTLE_CYC + 1);
  localparam int EW   = $clog2(ERR_THRESH + 1);

  align_st_e     st_q, st_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] set_q, set_d;
  logic [EW-1:0] err_q, err_d;
  logic          slip_q, slip_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= ST_HUNT;
      run_q  <= '0;
      tmo_q  <= '0;
      set_q  <= '0;
      err_q  <= '0;
      slip_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      run_q  <= run_d;
      tmo_q  <= tmo_d;
      set_q  <= set_d;
      err_q  <= err_d;
      slip_q <= slip_d;
    end
  end

  // tmo_q is the timeout counter in HUNT and the error window counter in LOCKED
  always_comb begin
    st_d   = st_q;
    run_d  = run_q;
    tmo_d  = tmo_q;
    set_d  = set_q;
    err_d  = err_q;
    slip_d = 1'b0;
    case (st_q)
      ST_HUNT: if (sym_val_i) begin
        run_d = sym_ctl_i ? run_q + RW'(1) : '0;
        tmo_d = tmo_q + TW'(1);
        if (sym_ctl_i && run_q == RW'(LOCK_CNT - 1)) begin
          st_d  = ST_LOCKED;
          run_d = '0;
          tmo_d = '0;
          err_d = '0;
        end else if (tmo_q == TW'(SLIP_TIMEOUT - 1)) begin
          st_d   = ST_SETTLE;
          slip_d = 1'b1;
          run_d  = '0;
          tmo_d  = '0;
          set_d  = '0;
        end
      end
      ST_SETTLE: begin
        set_d = set_q + SW'(1);
        if (set_q == SW'(SETTLE_CYC - 1)) begin
          st_d  = ST_HUNT;
          set_d = '0;
          run_d = '0;
        end
      end
      ST_LOCKED: if (sym_val_i) begin
        tmo_d = tmo_q + TW'(1);
        if (sym_err_i) err_d = err_q + EW'(1);
        if (sym_err_i && err_q == EW'(ERR_THRESH - 1)) begin
          st_d  = ST_HUNT;
          tmo_d = '0;
          err_d = '0;
          run_d = '0;
        end else if (tmo_q == TW'(ERR_WINDOW - 1)) begin
          tmo_d = '0;
          err_d = '0;
        end
      end
      default: st_d = ST_HUNT;
    endcase
  end

  assign bitslip_o = slip_q;
  assign locked_o  = (st_q == ST_LOCKED);

endmodule

// File: rtl/tmds_dec.sv
// TMDS 10b->8b channel decoder: two-stage classify/decode pipeline plus the
// alignment tracker, which observes the same symbols as stage 2.
module tmds_dec
  import tmds_pkg::*;
#(
  parameter int TMDS_CHANNEL = 0,
  parameter int LOCK_CNT     = 16,
  parameter int SLIP_TIMEOUT = 4096,
  parameter int SETTLE_CYC   = 16,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_THRESH   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] tmds_data_i,
  input  logic       tmds_data_val_i,
  output logic [7:0] px_data_o,
  output logic       px_data_val_o,
  output logic       gb_o,
  output logic       ctl_0_o,
  output logic       ctl_1_o,
  output logic       sym_err_o,
  output logic       bitslip_o,
  output logic       locked_o
);

  localparam logic [9:0] GB_CODE = (TMDS_CHANNEL == 1) ? GB_CH1 : GB_CH02;

  sym_cls_e   cls_d, s1_cls_q;
  logic [9:0] s1_sym_q;
  logic       s1_val_q;

  always_comb begin
    cls_d = SYM_VID;
    if (tmds_data_i == CTL_00 || tmds_data_i == CTL_01 ||
        tmds_data_i == CTL_10 || tmds_data_i == CTL_11)
      cls_d = SYM_CTL;
    else if (tmds_data_i == GB_CODE)
      cls_d = SYM_GB;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_val_q <= 1'b0;
      s1_sym_q <= '0;
      s1_cls_q <= SYM_VID;
    end else begin
      s1_val_q <= tmds_data_val_i;
      s1_sym_q <= tmds_data_i;
      s1_cls_q <= cls_d;
    end
  end

  logic [7:0] d, vid;
  logic [3:0] pop;
  logic       exp_xnor, vid_err, is_vid, is_ctl, is_gb;
  logic [1:0] ctl_bits;

  // The encoder picks XNOR for dense bytes; q[8] must agree with that choice.
  always_comb begin
    d      = s1_sym_q[9] ? ~s1_sym_q[7:0] : s1_sym_q[7:0];
    vid    = '0;
    vid[0] = d[0];
    for (int i = 1; i < 8; i++)
      vid[i] = s1_sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + 4'(vid[i]);
    exp_xnor = (pop > 4'd4) || (pop == 4'd4 && !vid[0]);
    vid_err  = (s1_sym_q[8] == exp_xnor);
  end

  always_comb begin
    ctl_bits = 2'b00;
    case (s1_sym_q)
      CTL_01:  ctl_bits = 2'b01;
      CTL_10:  ctl_bits = 2'b10;
      CTL_11:  ctl_bits = 2'b11;
      default: ctl_bits = 2'b00;
    endcase
  end

  assign is_vid = s1_val_q && s1_cls_q == SYM_VID;
  assign is_ctl = s1_val_q && s1_cls_q == SYM_CTL;
  assign is_gb  = s1_val_q && s1_cls_q == SYM_GB;

  logic [7:0] px_q;
  logic       pxv_q, gb_q, c0_q, c1_q, err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_q  <= '0;
      pxv_q <= 1'b0;
      gb_q  <= 1'b0;
      c0_q  <= 1'b0;
      c1_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pxv_q <= is_vid;
      gb_q  <= is_gb;
      err_q <= is_vid && vid_err;
      if (is_vid) px_q <= vid;
      if (is_ctl) {c1_q, c0_q} <= ctl_bits;
    end
  end

  assign px_data_o     = px_q;
  assign px_data_val_o = pxv_q;
  assign gb_o          = gb_q;
  assign ctl_0_o       = c0_q;
  assign ctl_1_o       = c1_q;
  assign sym_err_o     = err_q;

  tmds_align_fsm #(
    .LOCK_CNT    (LOCK_CNT),
    .SLIP_TIMEOUT(SLIP_TIMEOUT),
    .SETTLE_CYC  (SETTLE_CYC),
    .ERR_WINDOW  (ERR_WINDOW),
    .ERR_THRESH  (ERR_THRESH)
  ) u_fsm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sym_val_i(s1_val_q),
    .sym_ctl_i(is_ctl),
    .sym_err_i(is_vid && vid_err),
    .bitslip_o(bitslip_o),
    .locked_o (locked_o)
  );

endmodule

// File: tb/tb_tmds_dec.sv
// Directed-vector bench for tmds_dec; channel 0 and channel 1 instances share stimulus.
module tb_tmds_dec;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [9:0] tmds_data_i = '0;
  logic       tmds_data_val_i = 1'b0;

  logic [7:0] px0, px1;
  logic       pxv0, gb0, c00, c10, err0, slip0, lk0;
  logic       pxv1, gb1, c01, c11, err1, slip1, lk1;

  int nvec = 0;
  int nmis = 0;
  int nslip = 0;

  always #5 clk_i = ~clk_i;

  tmds_dec #(.TMDS_CHANNEL(0)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .tmds_data_i(tmds_data_i), .tmds_data_val_i(tmds_data_val_i),
    .px_data_o(px0), .px_data_val_o(pxv0), .gb_o(gb0), .ctl_0_o(c00), .ctl_1_o(c10),
    .sym_err_o(err0), .bitslip_o(slip0), .locked_o(lk0));

  tmds_dec #(.TMDS_CHANNEL(1)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .tmds_data_i(tmds_data_i), .tmds_data_val_i(tmds_data_val_i),
    .px_data_o(px1), .px_data_val_o(pxv1), .gb_o(gb1), .ctl_0_o(c01), .ctl_1_o(c11),
    .sym_err_o(err1), .bitslip_o(slip1), .locked_o(lk1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one symbol, advance one clock, sample 1ns after the edge.
  // The symbol driven in a step shows on the outputs after the following step.
  task automatic step(input logic [9:0] d, input logic v);
    tmds_data_i     = d;
    tmds_data_val_i = v;
    @(posedge clk_i);
    #1;
    if (slip0) nslip++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step(10'h0, 1'b0);
    step(10'h0, 1'b0);
    rst_i = 1'b0;
  endtask

  int slip_before;

  initial begin
    // reset state
    do_reset();
    chk("rst_out0", {px0, pxv0, gb0, c00, c10, err0, slip0, lk0}, '0);
    chk("rst_out1", {px1, pxv1, gb1, c01, c11, err1, slip1, lk1}, '0);

    // video decode and symbol error
    step(10'h100, 1'b1);
    step(10'h200, 1'b1);
    chk("v100", {px0, pxv0, err0}, {8'h00, 1'b1, 1'b0});
    step(10'h155, 1'b1);
    chk("v200", {px0, pxv0, err0}, {8'hFF, 1'b1, 1'b0});
    step(T11, 1'b1);
    chk("v155", {px0, pxv0, err0}, {8'hFF, 1'b1, 1'b1});
    step(10'h100, 1'b1);
    chk("ctl11_hold_px", {px0, pxv0, gb0, c10, c00, err0}, {8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    step(10'h0, 1'b0);
    chk("vid_hold_ctl", {px0, pxv0, c10, c00}, {8'h00, 1'b1, 1'b1, 1'b1});
    step(10'h0, 1'b0);
    chk("bubble", {px0, pxv0, gb0, err0, c10, c00}, {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

    // guard band per channel
    step(G1, 1'b1);
    step(G02, 1'b1);
    chk("gb_ch1", {gb1, pxv1}, {1'b1, 1'b0});
    chk("gb1_on_ch0", {px0, pxv0, gb0, err0}, {8'h55, 1'b1, 1'b0, 1'b0});
    step(10'h0, 1'b0);
    chk("gb_ch0", {px0, pxv0, gb0}, {8'h55, 1'b0, 1'b1});

    // lock on 16 control tokens
    do_reset();
    for (int i = 0; i < 16; i++) step(T10, 1'b1);
    chk("lock_pre16", lk0, 1'b0);
    step(10'h0, 1'b0);
    chk("lock_16", {lk0, c10, c00, pxv0}, {1'b1, 1'b1, 1'b0, 1'b0});

    // timeout -> bitslip -> settle -> hunt
    do_reset();
    slip_before = nslip;
    for (int i = 0; i < 4096; i++) step(10'h100, 1'b1);
    chk("slip_pre", slip0, 1'b0);
    step(10'h0, 1'b0);
    chk("slip_pulse", slip0, 1'b1);
    for (int i = 0; i < 31; i++) step(T10, 1'b1);
    chk("slip_once", nslip - slip_before, 1);
    chk("settle_ignored", lk0, 1'b0);
    step(10'h0, 1'b0);
    chk("relock_after_settle", lk0, 1'b1);

    // lock and timeout on the same symbol: lock wins
    do_reset();
    slip_before = nslip;
    for (int i = 0; i < 4080; i++) step(10'h100, 1'b1);
    for (int i = 0; i < 16; i++) step(T00, 1'b1);
    step(10'h0, 1'b0);
    step(10'h0, 1'b0);
    chk("tie_locked", lk0, 1'b1);
    chk("tie_noslip", nslip - slip_before, 0);

    // error window: 7 per window holds lock, 8 in one window drops it
    for (int i = 0; i < 7; i++) step(10'h155, 1'b1);
    for (int i = 0; i < 1017; i++) step(10'h100, 1'b1);
    for (int i = 0; i < 7; i++) step(10'h155, 1'b1);
    step(10'h0, 1'b0);
    chk("err7_locked", lk0, 1'b1);
    step(10'h155, 1'b1);
    step(10'h0, 1'b0);
    chk("err8_unlock", {lk0, err0}, {1'b0, 1'b1});

    // bubbles neither advance nor clear the run counter
    for (int k = 1; k <= 16; k++) begin
      step(T10, 1'b1);
      step(10'h0, 1'b0);
      if (k == 15) chk("bub_lock_pre", lk0, 1'b0);
    end
    chk("bub_lock", lk0, 1'b1);

    // reset while locked with alternating bubbles
    rst_i = 1'b1;
    step(T11, 1'b1);
    chk("rst_locked", {px0, pxv0, gb0, c00, c10, err0, slip0, lk0}, '0);
    rst_i = 1'b0;
    step(10'h200, 1'b1);
    chk("post_rst_lat", {px0, pxv0, lk0}, {8'h00, 1'b0, 1'b0});
    step(10'h0, 1'b0);
    chk("post_rst_out", {px0, pxv0, lk0}, {8'hFF, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
